// File: rtl/reg_arbiter_2p.sv
// reg_arbiter_2p: two-port arbiter in front of a single register bus.
// Each upstream port issues one write or read at a time. The arbiter grants
// one port, forwards the access downstream, and returns one ack/rdy strobe
// with an error flag. A request from the other port waits until the current
// transaction is fully retired. Contention is resolved round-robin against
// the last served port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_pN_wr_rdy / o_pN_wr_ack   port N write request / write-done strobe
//   i_pN_rd_req / o_pN_rd_rdy   port N read request / read-data-valid strobe
//   i_pN_address, i_pN_wdata    port N address and write data
//   o_pN_rdata, o_pN_invalid    port N read data and error flag (held)
//   o_reg_in_rdy / i_reg_in_ack_stb   downstream write request / ack
//   o_reg_out_req / i_reg_out_rdy     downstream read request / data valid
//   o_reg_address, o_reg_in_data      downstream address and write data
//   i_reg_out_data, i_reg_invalid_addr downstream read data and error
module reg_arbiter_2p #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_p0_wr_rdy,
  output logic                  o_p0_wr_ack,
  input  logic                  i_p0_rd_req,
  output logic                  o_p0_rd_rdy,
  input  logic [ADDR_WIDTH-1:0] i_p0_address,
  input  logic [DATA_WIDTH-1:0] i_p0_wdata,
  output logic [DATA_WIDTH-1:0] o_p0_rdata,
  output logic                  o_p0_invalid,
  input  logic                  i_p1_wr_rdy,
  output logic                  o_p1_wr_ack,
  input  logic                  i_p1_rd_req,
  output logic                  o_p1_rd_rdy,
  input  logic [ADDR_WIDTH-1:0] i_p1_address,
  input  logic [DATA_WIDTH-1:0] i_p1_wdata,
  output logic [DATA_WIDTH-1:0] o_p1_rdata,
  output logic                  o_p1_invalid,
  output logic                  o_reg_in_rdy,
  input  logic                  i_reg_in_ack_stb,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy,
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  output logic [DATA_WIDTH-1:0] o_reg_in_data,
  input  logic [DATA_WIDTH-1:0] i_reg_out_data,
  input  logic                  i_reg_invalid_addr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 1) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    gnt_q, gnt_d;
  logic                    op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    in_rdy_q, in_rdy_d;
  logic                    out_req_q, out_req_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              wr_ack_q, wr_ack_d;
  logic [1:0]              rd_rdy_q, rd_rdy_d;
  logic [1:0]              inv_q, inv_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

  logic                    req0, req1, pick, pick_wr;
  logic                    done, timed_out, fin_inv;
  logic [DATA_WIDTH-1:0]   fin_rdata;

  assign req0      = i_p0_wr_rdy | i_p0_rd_req;
  assign req1      = i_p1_wr_rdy | i_p1_rd_req;
  // On contention the port that was not served last wins.
  assign pick      = (req0 && req1) ? ~last_grant_q : req1;
  assign pick_wr   = pick ? i_p1_wr_rdy : i_p0_wr_rdy;
  // Only the completion input matching the operation type is honoured.
  assign done      = op_wr_q ? i_reg_in_ack_stb : i_reg_out_rdy;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign fin_inv   = done ? i_reg_invalid_addr : 1'b1;
  assign fin_rdata = done ? i_reg_out_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      in_rdy_q     <= 1'b0;
      out_req_q    <= 1'b0;
      cnt_q        <= '0;
      wr_ack_q     <= '0;
      rd_rdy_q     <= '0;
      inv_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      in_rdy_q     <= in_rdy_d;
      out_req_q    <= out_req_d;
      cnt_q        <= cnt_d;
      wr_ack_q     <= wr_ack_d;
      rd_rdy_q     <= rd_rdy_d;
      inv_q        <= inv_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    in_rdy_d     = in_rdy_q;
    out_req_d    = out_req_q;
    cnt_d        = cnt_q;
    wr_ack_d     = '0;
    rd_rdy_d     = '0;
    inv_d        = inv_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d     = pick;
          op_wr_d   = pick_wr;
          addr_d    = pick ? i_p1_address : i_p0_address;
          wdata_d   = pick ? i_p1_wdata : i_p0_wdata;
          in_rdy_d  = pick_wr;
          out_req_d = ~pick_wr;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (done || timed_out) begin
          in_rdy_d      = 1'b0;
          out_req_d     = 1'b0;
          inv_d[gnt_q]  = fin_inv;
          if (op_wr_q) begin
            wr_ack_d[gnt_q] = 1'b1;
          end else begin
            rd_rdy_d[gnt_q] = 1'b1;
            if (gnt_q) rdata1_d = fin_rdata;
            else       rdata0_d = fin_rdata;
          end
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Retire only once the served port has dropped its request, so a
        // still-held request is never mistaken for a new one.
        if (gnt_q ? !req1 : !req0) begin
          last_grant_d = gnt_q;
          state_d      = IDLE;
        end
      end
      default: begin
        in_rdy_d  = 1'b0;
        out_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_comb begin
    o_p0_wr_ack   = wr_ack_q[0];
    o_p1_wr_ack   = wr_ack_q[1];
    o_p0_rd_rdy   = rd_rdy_q[0];
    o_p1_rd_rdy   = rd_rdy_q[1];
    o_p0_invalid  = inv_q[0];
    o_p1_invalid  = inv_q[1];
    o_p0_rdata    = rdata0_q;
    o_p1_rdata    = rdata1_q;
    o_reg_in_rdy  = in_rdy_q;
    o_reg_out_req = out_req_q;
    o_reg_address = addr_q;
    o_reg_in_data = wdata_q;
  end

endmodule

// File: tb/tb_reg_arbiter_2p.sv
module tb_reg_arbiter_2p;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_p0_wr_rdy = 0, i_p0_rd_req = 0, i_p1_wr_rdy = 0, i_p1_rd_req = 0;
  logic [AW-1:0] i_p0_address = '0, i_p1_address = '0;
  logic [DW-1:0] i_p0_wdata = '0, i_p1_wdata = '0;
  logic          o_p0_wr_ack, o_p0_rd_rdy, o_p0_invalid, o_p1_wr_ack, o_p1_rd_rdy, o_p1_invalid;
  logic [DW-1:0] o_p0_rdata, o_p1_rdata;
  logic          o_reg_in_rdy, o_reg_out_req;
  logic          i_reg_in_ack_stb = 0, i_reg_out_rdy = 0, i_reg_invalid_addr = 0;
  logic [AW-1:0] o_reg_address;
  logic [DW-1:0] o_reg_in_data;
  logic [DW-1:0] i_reg_out_data = '0;

  always #5 clk = ~clk;

  reg_arbiter_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_p0_wr_rdy(i_p0_wr_rdy), .o_p0_wr_ack(o_p0_wr_ack), .i_p0_rd_req(i_p0_rd_req),
    .o_p0_rd_rdy(o_p0_rd_rdy), .i_p0_address(i_p0_address), .i_p0_wdata(i_p0_wdata),
    .o_p0_rdata(o_p0_rdata), .o_p0_invalid(o_p0_invalid),
    .i_p1_wr_rdy(i_p1_wr_rdy), .o_p1_wr_ack(o_p1_wr_ack), .i_p1_rd_req(i_p1_rd_req),
    .o_p1_rd_rdy(o_p1_rd_rdy), .i_p1_address(i_p1_address), .i_p1_wdata(i_p1_wdata),
    .o_p1_rdata(o_p1_rdata), .o_p1_invalid(o_p1_invalid),
    .o_reg_in_rdy(o_reg_in_rdy), .i_reg_in_ack_stb(i_reg_in_ack_stb),
    .o_reg_out_req(o_reg_out_req), .i_reg_out_rdy(i_reg_out_rdy),
    .o_reg_address(o_reg_address), .o_reg_in_data(o_reg_in_data),
    .i_reg_out_data(i_reg_out_data), .i_reg_invalid_addr(i_reg_invalid_addr)
  );

  logic [3:0] stb;
  assign stb = {o_p0_wr_ack, o_p0_rd_rdy, o_p1_wr_ack, o_p1_rd_rdy};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] stbv(input int p, input bit wr);
    if (p == 0) return wr ? 4'b1000 : 4'b0100;
    return wr ? 4'b0010 : 4'b0001;
  endfunction

  task automatic set_port(input int p, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      i_p0_wr_rdy = wr; i_p0_rd_req = rd; i_p0_address = a; i_p0_wdata = d;
    end else begin
      i_p1_wr_rdy = wr; i_p1_rd_req = rd; i_p1_address = a; i_p1_wdata = d;
    end
  endtask

  task automatic clear_down();
    i_reg_in_ack_stb = 0; i_reg_out_rdy = 0; i_reg_invalid_addr = 0; i_reg_out_data = '0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {stb, o_p0_invalid, o_p1_invalid, o_reg_in_rdy, o_reg_out_req}, '0);
    chk({name, "_bus"}, {o_reg_address, o_reg_in_data, o_p0_rdata, o_p1_rdata}, '0);
  endtask

  task automatic do_reset(input string name);
    rst = 1;
    set_port(0, 0, 0, '0, '0);
    set_port(1, 0, 0, '0, '0);
    clear_down();
    step();
    chk_all_zero(name);
    step();
    rst = 0;
  endtask

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          dly;
    bit          respond;
    logic [31:0] rdata;
    bit          inv;
    int          exp_lat;
    bit          exp_inv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // Single-port transaction: grant, wait with wrong-type completion noise,
  // then compare latency, strobe, error flag and read data.
  task automatic do_vec(input vec_t v, input int idx);
    int lat;
    set_port(v.port, v.wr, !v.wr, v.addr, v.wdata);
    step();
    chk($sformatf("vec%0d_req", idx), {o_reg_in_rdy, o_reg_out_req}, v.wr ? 2'b10 : 2'b01);
    chk($sformatf("vec%0d_addr", idx), o_reg_address, v.addr);
    if (v.wr) chk($sformatf("vec%0d_wdata", idx), o_reg_in_data, v.wdata);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      i_reg_out_data     = v.rdata;
      i_reg_invalid_addr = (v.respond && k == v.dly) ? v.inv : ~v.inv;
      i_reg_in_ack_stb   = v.wr ? (v.respond && k == v.dly) : 1'b1;
      i_reg_out_rdy      = v.wr ? 1'b1 : (v.respond && k == v.dly);
      step();
      if (stb != 4'b0000) begin
        lat = k + 1;
        break;
      end
    end
    clear_down();
    chk($sformatf("vec%0d_lat", idx), lat, v.exp_lat);
    chk($sformatf("vec%0d_stb", idx), stb, stbv(v.port, v.wr));
    chk($sformatf("vec%0d_inv", idx), v.port == 0 ? o_p0_invalid : o_p1_invalid, v.exp_inv);
    if (!v.wr) chk($sformatf("vec%0d_rdata", idx), v.port == 0 ? o_p0_rdata : o_p1_rdata, v.exp_rdata);
    chk($sformatf("vec%0d_reqoff", idx), {o_reg_in_rdy, o_reg_out_req}, 2'b00);
    set_port(v.port, 0, 0, v.addr, v.wdata);
    step();
    step();
  endtask

  // Wait for the next downstream request, check who got it, complete it.
  task automatic serve(input int p, input logic [31:0] a, input bit wr,
                       input logic [31:0] rd, input bit inv, input string tag);
    int w = 0;
    while (!(o_reg_in_rdy || o_reg_out_req) && w < 10) begin
      step();
      w++;
    end
    chk({tag, "_addr"}, o_reg_address, a);
    chk({tag, "_type"}, {o_reg_in_rdy, o_reg_out_req}, wr ? 2'b10 : 2'b01);
    if (wr) i_reg_in_ack_stb = 1; else i_reg_out_rdy = 1;
    i_reg_out_data = rd;
    i_reg_invalid_addr = inv;
    step();
    clear_down();
    chk({tag, "_stb"}, stb, stbv(p, wr));
    chk({tag, "_inv"}, p == 0 ? o_p0_invalid : o_p1_invalid, inv);
    if (!wr) chk({tag, "_rdata"}, p == 0 ? o_p0_rdata : o_p1_rdata, rd);
    set_port(p, 0, 0, a, '0);
    step();
  endtask

  // Randomized-phase reference model state
  bit          pend[2], pwr[2], pboth[2], prev_req[2];
  logic [31:0] paddr[2], pdata[2];
  int          gap[2];
  logic [31:0] exp_rd[2];
  bit          exp_iv[2];
  int          last_srv, cur_port, done_at, resp_at, ep;
  bit          busy, cur_wr, resp_inv, on_time, respond, stop;
  logic [31:0] cur_addr, resp_data;
  int          d;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 1, 32'h10, 32'hA5A5A5A5, 3, 1, 32'h0,        0, 4, 0, 32'h0};
    vecs[1] = '{1, 1, 32'h20, 32'h0BADF00D, 0, 1, 32'h0,        1, 1, 1, 32'h0};
    vecs[2] = '{0, 0, 32'h30, 32'h0,        2, 1, 32'hDEADBEEF, 0, 3, 0, 32'hDEADBEEF};
    vecs[3] = '{0, 0, 32'h34, 32'h0,        0, 0, 32'hFFFFFFFF, 0, 8, 1, 32'h0};
    vecs[4] = '{1, 0, 32'h40, 32'h0,        7, 1, 32'h12345678, 0, 8, 0, 32'h12345678};
    vecs[5] = '{1, 1, 32'h44, 32'h77,       8, 1, 32'h0,        0, 8, 1, 32'h0};
    vecs[6] = '{1, 0, 32'h48, 32'h0,        4, 1, 32'h55AA55AA, 1, 5, 1, 32'h55AA55AA};

    step();
    do_reset("reset");

    for (int i = 0; i < 7; i++) do_vec(vecs[i], i);

    // Simultaneous reads after reset: port 0 first, then port 1.
    do_reset("resetA");
    set_port(0, 0, 1, 32'h100, '0);
    set_port(1, 0, 1, 32'h200, '0);
    serve(0, 32'h100, 0, 32'h11111111, 0, "A0");
    serve(1, 32'h200, 0, 32'h22222222, 0, "A1");
    chk("A_p0_hold", o_p0_rdata, 32'h11111111);

    // Port 1 read held while port 0 keeps writing: strict alternation.
    set_port(1, 0, 1, 32'h300, '0);
    set_port(0, 1, 1, 32'h400, 32'hCAFE0001);
    serve(0, 32'h400, 1, '0, 0, "B0");
    set_port(0, 1, 0, 32'h404, 32'hCAFE0002);
    serve(1, 32'h300, 0, 32'h33333333, 0, "B1");
    set_port(1, 0, 1, 32'h304, '0);
    serve(0, 32'h404, 1, '0, 1, "B2");
    set_port(0, 1, 0, 32'h408, 32'hCAFE0003);
    serve(1, 32'h304, 0, 32'h44444444, 0, "B3");
    serve(0, 32'h408, 1, '0, 0, "B4");

    // Reset during ISSUE aborts the write without any strobe.
    set_port(0, 1, 0, 32'h500, 32'h5);
    step();
    step();
    chk("C_issue", {o_reg_in_rdy, o_reg_address}, {1'b1, 32'h500});
    rst = 1;
    set_port(0, 0, 0, '0, '0);
    step();
    chk_all_zero("C_rst");
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      i_reg_in_ack_stb = 1; i_reg_out_rdy = 1;
      step();
      chk("C_nostb", {stb, o_reg_in_rdy, o_reg_out_req}, '0);
    end
    clear_down();
    set_port(1, 1, 0, 32'h600, 32'h6);
    serve(1, 32'h600, 1, '0, 1, "C_after");

    // Randomized traffic against a transaction-level model.
    do_reset("resetR");
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; prev_req[p] = 0; gap[p] = 0; exp_rd[p] = '0; exp_iv[p] = 0;
    end
    last_srv = 1; busy = 0; resp_at = -1; stop = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      stop = (cyc >= 3500);
      if (busy && cyc == done_at) begin
        if (!cur_wr) exp_rd[cur_port] = on_time ? resp_data : 32'h0;
        exp_iv[cur_port] = on_time ? resp_inv : 1'b1;
        chk("rnd_stb", stb, stbv(cur_port, cur_wr));
      end else begin
        chk("rnd_stb", stb, 4'b0000);
      end
      chk("rnd_rdinv", {o_p0_rdata, o_p1_rdata, o_p0_invalid, o_p1_invalid},
          {exp_rd[0], exp_rd[1], exp_iv[0], exp_iv[1]});
      if (busy && cyc < done_at) begin
        chk("rnd_hold", {o_reg_in_rdy, o_reg_out_req, o_reg_address}, {cur_wr, !cur_wr, cur_addr});
      end else if (busy) begin
        chk("rnd_release", {o_reg_in_rdy, o_reg_out_req}, 2'b00);
        busy = 0;
        pend[cur_port] = 0;
        last_srv = cur_port;
        gap[cur_port] = $urandom_range(1, 4);
      end else if (o_reg_in_rdy || o_reg_out_req) begin
        if (prev_req[0] && prev_req[1]) ep = 1 - last_srv;
        else if (prev_req[0]) ep = 0;
        else if (prev_req[1]) ep = 1;
        else ep = -1;
        chk("rnd_has_req", ep >= 0, 1'b1);
        if (ep >= 0) begin
          chk("rnd_grant", {o_reg_in_rdy, o_reg_out_req, o_reg_address},
              {pwr[ep], !pwr[ep], paddr[ep]});
          if (pwr[ep]) chk("rnd_wdata", o_reg_in_data, pdata[ep]);
          busy = 1; cur_port = ep; cur_wr = pwr[ep]; cur_addr = paddr[ep];
          respond = ($urandom_range(0, 9) != 0);
          d = $urandom_range(0, 9);
          resp_at = respond ? cyc + d : -1;
          on_time = respond && (d + 1 <= TO);
          done_at = cyc + (on_time ? d + 1 : TO);
          resp_data = $urandom;
          resp_inv = $urandom_range(0, 1);
        end
      end
      // downstream responder
      clear_down();
      if (cyc == resp_at) begin
        if (cur_wr) i_reg_in_ack_stb = 1; else i_reg_out_rdy = 1;
        i_reg_out_data = resp_data;
        i_reg_invalid_addr = resp_inv;
      end else if (busy) begin
        if (cur_wr) i_reg_out_rdy = $urandom_range(0, 1);
        else i_reg_in_ack_stb = $urandom_range(0, 1);
        i_reg_out_data = $urandom;
        i_reg_invalid_addr = $urandom_range(0, 1);
      end
      // upstream requesters
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if (gap[p] > 0) gap[p]--;
          else if (!stop && $urandom_range(0, 2) == 0) begin
            pend[p] = 1; pwr[p] = $urandom_range(0, 1); pboth[p] = $urandom_range(0, 1);
            paddr[p] = $urandom; pdata[p] = $urandom;
          end
        end
        set_port(p, pend[p] && pwr[p], pend[p] && (!pwr[p] || pboth[p]),
                 pend[p] ? paddr[p] : $urandom, pend[p] ? pdata[p] : $urandom);
        prev_req[p] = pend[p];
      end
      if (stop && !busy && !pend[0] && !pend[1]) break;
    end
    chk("rnd_drained", {busy, pend[0], pend[1]}, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_arbiter_2p.md
REG_ARBITER_2P -- requirements
Module: reg_arbiter_2p

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width on all ports.
REQ-003 Parameter TIMEOUT, default 256, downstream wait limit in cycles; 0 disables timeout.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i_pN_wr_rdy  input  1  (N=0,1) port N write request, held until acknowledged.
REQ-007 o_pN_wr_ack  output  1  port N write-done strobe, one cycle.
REQ-008 i_pN_rd_req  input  1  port N read request, held until transaction ends.
REQ-009 o_pN_rd_rdy  output  1  port N read-data-valid strobe, one cycle.
REQ-010 i_pN_address  input  ADDR_WIDTH  port N register address.
REQ-011 i_pN_wdata  input  DATA_WIDTH  port N write data.
REQ-012 o_pN_rdata  output  DATA_WIDTH  port N read data.
REQ-013 o_pN_invalid  output  1  port N error flag, valid with ack/rdy strobe.
REQ-014 o_reg_in_rdy  output  1  downstream write request.
REQ-015 i_reg_in_ack_stb  input  1  downstream write acknowledge.
REQ-016 o_reg_out_req  output  1  downstream read request.
REQ-017 i_reg_out_rdy  input  1  downstream read data valid.
REQ-018 o_reg_address  output  ADDR_WIDTH  downstream address.
REQ-019 o_reg_in_data  output  DATA_WIDTH  downstream write data.
REQ-020 i_reg_out_data  input  DATA_WIDTH  downstream read data.
REQ-021 i_reg_invalid_addr  input  1  downstream address error, sampled with ack/rdy.

Function
REQ-022 States: IDLE, ISSUE, DRAIN; all outputs registered.
REQ-023 Port N requests when i_pN_wr_rdy or i_pN_rd_req is high; write wins if both are high on one port.
REQ-024 IDLE: one requesting port -> grant it; two -> grant port other than last_grant; last_grant = 1 after reset, so port 0 wins first contention.
REQ-025 On grant: latch port id, op type, address, wdata; next cycle o_reg_address/o_reg_in_data valid and o_reg_in_rdy (write) or o_reg_out_req (read) = 1; -> ISSUE; timeout counter cleared.
REQ-026 ISSUE: downstream request held high, address/data held stable until completion.
REQ-027 Completion = i_reg_in_ack_stb (write) or i_reg_out_rdy (read) in ISSUE; wrong-type completion input ignored.
REQ-028 On completion: downstream request low next cycle; granted port ack/rdy strobe high exactly one cycle; o_pN_invalid = i_reg_invalid_addr; read -> o_pN_rdata = i_reg_out_data; -> DRAIN.
REQ-029 Timeout: TIMEOUT != 0 and counter reaches TIMEOUT-1 in ISSUE without completion -> same as completion but invalid = 1, rdata = 0.
REQ-030 Completion and timeout in same cycle: completion wins.
REQ-031 o_pN_rdata, o_pN_invalid hold until port N's next completion.
REQ-032 DRAIN: wait until granted port's request inputs both low; then last_grant = granted port, -> IDLE; no new grant in the exit cycle.
REQ-033 Ungranted port requests held during ISSUE/DRAIN are served later; never dropped.
REQ-034 Strobes never go to the ungranted port; at most one downstream request active.
REQ-035 Unreachable state -> IDLE, outputs deasserted.

Reset
REQ-036 rst high: state IDLE, all strobes/requests 0, o_reg_address/o_reg_in_data/o_pN_rdata 0, o_pN_invalid 0, last_grant 1, counter 0.
REQ-037 rst mid-transaction aborts it; no strobe issued to either port after reset.

Verification
REQ-038 P0 write addr 0x10 data 0xA5A5A5A5, ack after 3 cycles -> o_reg_in_data 0xA5A5A5A5, one o_p0_wr_ack pulse, invalid 0.
REQ-039 P0 and P1 reads raised same cycle after reset -> P0 served first, then P1; rdata 0x11111111/0x22222222 routed correctly.
REQ-040 P1 read held continuously across three transactions with P0 repeatedly requesting -> strict alternation P0,P1,P0.
REQ-041 TIMEOUT=8, no downstream response -> o_p0_rd_rdy after 8 ISSUE cycles, invalid 1, rdata 0, o_reg_out_req deasserted.
REQ-042 Write with i_reg_invalid_addr=1 at ack -> o_p1_invalid 1 with o_p1_wr_ack.
REQ-043 rst asserted during ISSUE -> all outputs 0 next cycle, no ack/rdy strobe, next request served normally.
